// File: rtl/alut_pkg11.sv
// ---------------------------------------------------------------------------
// alut_pkg11
// Shared definitions for the ALUT age scanner:
//   - entry field positions: [82] valid, [81:50] timestamp, [49:48] port,
//     [47:0] MAC
//   - default entry / timestamp widths and entry count
//   - scanner FSM state encoding
// ---------------------------------------------------------------------------
package alut_pkg11;

  localparam int DW_DEF = 83;
  localparam int TW_DEF = 32;
  localparam int DD_DEF = 256;

  localparam int VALID_BIT = 82;
  localparam int TS_MSB    = 81;
  localparam int TS_LSB    = 50;
  localparam int PORT_MSB  = 49;
  localparam int PORT_LSB  = 48;
  localparam int MAC_MSB   = 47;
  localparam int MAC_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CHECK = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } age_state_e;

endpackage

// File: rtl/alut_age_cmp11.sv
// ---------------------------------------------------------------------------
// alut_age_cmp11
// Combinational modular age comparator.
//   time_snap  in  TW  time captured at scan start
//   timestamp  in  TW  entry timestamp
//   thresh     in  TW  age limit
//   aged       out 1   (time_snap - timestamp) mod 2^TW > thresh
// The subtraction wraps, so an entry learned just before the time counter
// rolled over still gets a small, correct age.
// ---------------------------------------------------------------------------
module alut_age_cmp11 #(
  parameter int TW = 32
) (
  input  logic [TW-1:0] time_snap,
  input  logic [TW-1:0] timestamp,
  input  logic [TW-1:0] thresh,
  output logic          aged
);

  logic [TW-1:0] age;

  assign age  = time_snap - timestamp;
  assign aged = (age > thresh);

endmodule

// File: rtl/alut_age_scanner11.sv
// ---------------------------------------------------------------------------
// alut_age_scanner11
// Age-scan initiator for the ALUT entry memory. A start pulse walks every
// entry through the age port; valid entries older than the threshold are
// written back with the valid bit cleared. Writes from the address checker
// (add port) are snooped so a freshly learned entry is never overwritten.
//
// Ports:
//   pclk11                in  1   clock
//   p_reset11             in  1   asynchronous active-high reset
//   scan_start11          in  1   start request (ignored unless idle)
//   age_thresh11          in  TW  age limit, captured at start
//   curr_time11           in  TW  current time, captured at start
//   add_wr11              in  1   add-port write strobe (snoop)
//   add_addr11            in  8   add-port address (snoop)
//   mem_read_data_age11   in  DW  registered read data from age port
//   mem_addr_age11        out 8   entry address
//   mem_write_age11       out 1   write enable
//   mem_write_data_age11  out DW  write-back data
//   scan_busy11           out 1   scan in progress
//   scan_done11           out 1   one-cycle completion pulse
//   aged_count11          out 9   entries invalidated in last scan
//   valid_count11         out 9   valid entries seen in last scan
//
// Configuration macro: ALUT_AGE_STATS_EN -- when defined, the two count
// outputs are maintained; otherwise they are tied to zero.
// ---------------------------------------------------------------------------
module alut_age_scanner11
  import alut_pkg11::*;
#(
  parameter int DW = DW_DEF,
  parameter int DD = DD_DEF,
  parameter int TW = TW_DEF
) (
  input  logic          pclk11,
  input  logic          p_reset11,
  input  logic          scan_start11,
  input  logic [TW-1:0] age_thresh11,
  input  logic [TW-1:0] curr_time11,
  input  logic          add_wr11,
  input  logic [7:0]    add_addr11,
  input  logic [DW-1:0] mem_read_data_age11,
  output logic [7:0]    mem_addr_age11,
  output logic          mem_write_age11,
  output logic [DW-1:0] mem_write_data_age11,
  output logic          scan_busy11,
  output logic          scan_done11,
  output logic [8:0]    aged_count11,
  output logic [8:0]    valid_count11
);

  localparam logic [7:0]    LAST_IDX   = 8'(DD - 1);
  localparam logic [DW-1:0] VALID_MASK = DW'(1) << VALID_BIT;

  age_state_e    state_q, state_d;
  logic [7:0]    idx_q, idx_d;
  logic [TW-1:0] thresh_q, thresh_d;
  logic [TW-1:0] time_q, time_d;
  logic          cancel_q, cancel_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          snoop_hit;
  logic          rd_valid;
  logic          ts_aged;
  logic          entry_aged;
  logic          write_ok;
  logic          start_ok;
  logic [DW-1:0] rd_invalidated;

  alut_age_cmp11 #(.TW(TW)) u_age_cmp (
    .time_snap (time_q),
    .timestamp (mem_read_data_age11[TS_MSB:TS_LSB]),
    .thresh    (thresh_q),
    .aged      (ts_aged)
  );

  assign snoop_hit      = add_wr11 && (add_addr11 == idx_q);
  assign rd_valid       = mem_read_data_age11[VALID_BIT];
  assign entry_aged     = rd_valid && ts_aged;
  assign rd_invalidated = mem_read_data_age11 & ~VALID_MASK;
  assign start_ok       = (state_q == ST_IDLE) && scan_start11;

  // A same-cycle add-port write to this entry suppresses the write-back
  // combinationally, so the learned data always wins.
  assign write_ok = (state_q == ST_WRITE) && !snoop_hit;

  // NOTE: every signal gets a default at the top of the block, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    thresh_d  = thresh_q;
    time_d    = time_q;
    cancel_d  = cancel_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (scan_start11) begin
          thresh_d = age_thresh11;
          time_d   = curr_time11;
          idx_d    = '0;
          cancel_d = 1'b0;
          state_d  = ST_READ;
        end
      end
      ST_READ: begin
        if (snoop_hit) cancel_d = 1'b1;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (entry_aged && !(cancel_q || snoop_hit)) begin
          wr_data_d = rd_invalidated;
          state_d   = ST_WRITE;
        end else begin
          cancel_d = 1'b0;
          idx_d    = (idx_q == LAST_IDX) ? '0 : idx_q + 8'd1;
          state_d  = (idx_q == LAST_IDX) ? ST_DONE : ST_READ;
        end
      end
      ST_WRITE: begin
        cancel_d = 1'b0;
        idx_d    = (idx_q == LAST_IDX) ? '0 : idx_q + 8'd1;
        state_d  = (idx_q == LAST_IDX) ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_READ) || (state_d == ST_CHECK) ||
             (state_d == ST_WRITE);
  end

  // NOTE: asynchronous reset puts the FSM back in IDLE the instant it
  // asserts, so the combinational write enable drops in the same cycle.
  always_ff @(posedge pclk11 or posedge p_reset11) begin
    if (p_reset11) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      thresh_q  <= '0;
      time_q    <= '0;
      cancel_q  <= 1'b0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all flops updating from the
      // pre-edge values, independent of statement order.
      state_q   <= state_d;
      idx_q     <= idx_d;
      thresh_q  <= thresh_d;
      time_q    <= time_d;
      cancel_q  <= cancel_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign mem_addr_age11       = idx_q;
  assign mem_write_age11      = write_ok;
  assign mem_write_data_age11 = wr_data_q;
  assign scan_busy11          = busy_q;
  assign scan_done11          = done_q;

`ifdef ALUT_AGE_STATS_EN
  logic [8:0] aged_cnt_q, aged_cnt_d;
  logic [8:0] valid_cnt_q, valid_cnt_d;

  // Counts only clear on an accepted start, so they stay readable after DONE.
  always_comb begin
    aged_cnt_d  = aged_cnt_q;
    valid_cnt_d = valid_cnt_q;
    if (start_ok) begin
      aged_cnt_d  = '0;
      valid_cnt_d = '0;
    end else begin
      if ((state_q == ST_CHECK) && rd_valid) valid_cnt_d = valid_cnt_q + 9'd1;
      if (write_ok)                          aged_cnt_d  = aged_cnt_q + 9'd1;
    end
  end

  always_ff @(posedge pclk11 or posedge p_reset11) begin
    if (p_reset11) begin
      aged_cnt_q  <= '0;
      valid_cnt_q <= '0;
    end else begin
      aged_cnt_q  <= aged_cnt_d;
      valid_cnt_q <= valid_cnt_d;
    end
  end

  assign aged_count11  = aged_cnt_q;
  assign valid_count11 = valid_cnt_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign aged_count11    = '0;
  assign valid_count11   = '0;
`endif

endmodule

// File: tb/tb_alut_age_scanner11.sv
// ---------------------------------------------------------------------------
// tb_alut_age_scanner11
// Directed bench for alut_age_scanner11 with a behavioural ALUT memory
// (registered read on the age port, write ports for age and add).
// Expected count values depend on whether ALUT_AGE_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_alut_age_scanner11;

  localparam int DW = 83;
  localparam int TW = 32;

`ifdef ALUT_AGE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          pclk11 = 1'b0;
  logic          p_reset11;
  logic          scan_start11;
  logic [TW-1:0] age_thresh11;
  logic [TW-1:0] curr_time11;
  logic          add_wr11;
  logic [7:0]    add_addr11;
  logic [DW-1:0] add_data;
  logic [DW-1:0] mem_read_data_age11;
  logic [7:0]    mem_addr_age11;
  logic          mem_write_age11;
  logic [DW-1:0] mem_write_data_age11;
  logic          scan_busy11;
  logic          scan_done11;
  logic [8:0]    aged_count11;
  logic [8:0]    valid_count11;

  alut_age_scanner11 dut (
    .pclk11               (pclk11),
    .p_reset11            (p_reset11),
    .scan_start11         (scan_start11),
    .age_thresh11         (age_thresh11),
    .curr_time11          (curr_time11),
    .add_wr11             (add_wr11),
    .add_addr11           (add_addr11),
    .mem_read_data_age11  (mem_read_data_age11),
    .mem_addr_age11       (mem_addr_age11),
    .mem_write_age11      (mem_write_age11),
    .mem_write_data_age11 (mem_write_data_age11),
    .scan_busy11          (scan_busy11),
    .scan_done11          (scan_done11),
    .aged_count11         (aged_count11),
    .valid_count11        (valid_count11)
  );

  always #5 pclk11 = ~pclk11;

  // Memory model: age-port write first so a same-edge add write wins.
  logic [DW-1:0] mem [256];
  int            age_wr_cnt  = 0;
  logic [7:0]    last_wr_addr = '0;

  always @(posedge pclk11) begin
    if (mem_write_age11) begin
      mem[mem_addr_age11] <= mem_write_data_age11;
      age_wr_cnt          <= age_wr_cnt + 1;
      last_wr_addr        <= mem_addr_age11;
    end
    if (add_wr11) mem[add_addr11] <= add_data;
    mem_read_data_age11 <= mem[mem_addr_age11];
  end

  int cyc = 0;
  always @(posedge pclk11) cyc <= cyc + 1;

  int done_pulses = 0;
  int done_cyc    = 0;
  always @(negedge pclk11) begin
    if (scan_done11) begin
      done_pulses = done_pulses + 1;
      done_cyc    = cyc;
    end
  end

  int checks = 0;
  int errors = 0;
  int t0, done_base, wr_base, lat;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input bit v, input logic [31:0] ts,
                                       input logic [1:0] port,
                                       input logic [47:0] mac);
    return {v, ts, port, mac};
  endfunction

  task automatic load(input logic [7:0] a, input logic [DW-1:0] d);
    @(negedge pclk11);
    add_wr11   = 1'b1;
    add_addr11 = a;
    add_data   = d;
    @(posedge pclk11);
    #1;
    add_wr11 = 1'b0;
  endtask

  task automatic start_scan(input logic [TW-1:0] th, input logic [TW-1:0] t);
    @(negedge pclk11);
    age_thresh11 = th;
    curr_time11  = t;
    scan_start11 = 1'b1;
    done_base    = done_pulses;
    wr_base      = age_wr_cnt;
    @(posedge pclk11);
    #1;
    scan_start11 = 1'b0;
    t0 = cyc;
  endtask

  // Latency counts the start-sampling edge through the edge raising done.
  task automatic wait_done(output int latency);
    int n;
    n = 0;
    while (done_pulses == done_base && n < 3000) begin
      @(negedge pclk11);
      #1;
      n++;
    end
    if (done_pulses == done_base) begin
      checks++;
      errors++;
      $error("FAIL done_timeout: observed no done pulse expected a pulse");
      latency = 0;
    end else begin
      latency = done_cyc - t0 + 1;
    end
  endtask

  logic [DW-1:0] e5, e7, e9, fresh, e3;

  initial begin
    p_reset11    = 1'b1;
    scan_start11 = 1'b0;
    age_thresh11 = '0;
    curr_time11  = '0;
    add_wr11     = 1'b0;
    add_addr11   = '0;
    add_data     = '0;

    // Reset values
    repeat (2) @(negedge pclk11);
    check("rst_addr",  mem_addr_age11, 0);
    check("rst_wr",    mem_write_age11, 0);
    check("rst_wdata", mem_write_data_age11, 0);
    check("rst_busy",  scan_busy11, 0);
    check("rst_done",  scan_done11, 0);
    check("rst_aged",  aged_count11, 0);
    check("rst_valid", valid_count11, 0);
    p_reset11 = 1'b0;

    for (int i = 0; i < 256; i++) load(8'(i), '0);

    // All invalid; a second start at cycle 10 is ignored
    start_scan(32'd50, 32'd100);
    repeat (9) @(posedge pclk11);
    @(negedge pclk11);
    scan_start11 = 1'b1;
    check("busy_mid", scan_busy11, 1);
    @(posedge pclk11);
    #1;
    scan_start11 = 1'b0;
    wait_done(lat);
    check("empty_latency", lat, 514);
    check("empty_writes", age_wr_cnt - wr_base, 0);
    check("empty_aged", aged_count11, 0);
    check("empty_valid", valid_count11, 0);
    check("empty_busy_at_done", scan_busy11, 0);
    repeat (4) @(negedge pclk11);
    check("single_done_pulse", done_pulses - done_base, 1);
    check("done_low_after", scan_done11, 0);

    // Entry 5 aged: diff 90 > 50
    e5 = mk(1'b1, 32'd10, 2'd1, 48'h0000_1122_3344);
    load(8'd5, e5);
    start_scan(32'd50, 32'd100);
    wait_done(lat);
    check("e5_latency", lat, 515);
    check("e5_writes", age_wr_cnt - wr_base, 1);
    check("e5_wr_addr", last_wr_addr, 5);
    check("e5_mem", mem[5], mk(1'b0, 32'd10, 2'd1, 48'h0000_1122_3344));
    check("e5_aged", aged_count11, STATS ? 9'd1 : 9'd0);
    check("e5_valid", valid_count11, STATS ? 9'd1 : 9'd0);

    // Entry 7 across timestamp wrap: diff 0x20 > 0x1F
    e7 = mk(1'b1, 32'hFFFF_FFF0, 2'd2, 48'hAABB_CCDD_EEFF);
    load(8'd7, e7);
    start_scan(32'h1F, 32'h10);
    wait_done(lat);
    check("e7_latency", lat, 515);
    check("e7_writes", age_wr_cnt - wr_base, 1);
    check("e7_mem", mem[7], mk(1'b0, 32'hFFFF_FFF0, 2'd2, 48'hAABB_CCDD_EEFF));
    check("e7_aged", aged_count11, STATS ? 9'd1 : 9'd0);

    // Equality is not aged
    load(8'd7, e7);
    start_scan(32'h20, 32'h10);
    wait_done(lat);
    check("e7eq_latency", lat, 514);
    check("e7eq_writes", age_wr_cnt - wr_base, 0);
    check("e7eq_mem", mem[7], e7);
    check("e7eq_aged", aged_count11, 0);
    check("e7eq_valid", valid_count11, STATS ? 9'd1 : 9'd0);
    load(8'd7, '0);

    // Entry 9 aged, add-port write during CHECK (cycle after edge 19)
    e9    = mk(1'b1, 32'd0, 2'd0, 48'h0000_0000_0009);
    fresh = mk(1'b1, 32'd1000, 2'd3, 48'h1234_5678_9ABC);
    load(8'd9, e9);
    start_scan(32'd10, 32'd1000);
    repeat (19) @(posedge pclk11);
    @(negedge pclk11);
    check("snpchk_addr", mem_addr_age11, 9);
    add_wr11   = 1'b1;
    add_addr11 = 8'd9;
    add_data   = fresh;
    @(posedge pclk11);
    #1;
    add_wr11 = 1'b0;
    wait_done(lat);
    check("snpchk_latency", lat, 514);
    check("snpchk_writes", age_wr_cnt - wr_base, 0);
    check("snpchk_mem", mem[9], fresh);
    check("snpchk_aged", aged_count11, 0);
    check("snpchk_valid", valid_count11, STATS ? 9'd1 : 9'd0);

    // Entry 9 aged, add-port write during WRITE (cycle after edge 20)
    load(8'd9, e9);
    start_scan(32'd10, 32'd1000);
    repeat (20) @(posedge pclk11);
    @(negedge pclk11);
    check("snpwr_wr_before", mem_write_age11, 1);
    add_wr11   = 1'b1;
    add_addr11 = 8'd9;
    add_data   = fresh;
    #1;
    check("snpwr_wr_forced", mem_write_age11, 0);
    @(posedge pclk11);
    #1;
    add_wr11 = 1'b0;
    wait_done(lat);
    check("snpwr_latency", lat, 515);
    check("snpwr_writes", age_wr_cnt - wr_base, 0);
    check("snpwr_mem", mem[9], fresh);
    check("snpwr_aged", aged_count11, 0);
    load(8'd9, '0);

    // Reset during WRITE of entry 3 (cycle after edge 8)
    e3 = mk(1'b1, 32'd5, 2'd1, 48'h0000_0000_0303);
    load(8'd3, e3);
    start_scan(32'd10, 32'd100);
    repeat (8) @(posedge pclk11);
    @(negedge pclk11);
    check("rstw_wr_before", mem_write_age11, 1);
    p_reset11 = 1'b1;
    #1;
    check("rstw_wr", mem_write_age11, 0);
    check("rstw_addr", mem_addr_age11, 0);
    check("rstw_wdata", mem_write_data_age11, 0);
    check("rstw_busy", scan_busy11, 0);
    check("rstw_valid", valid_count11, 0);
    @(negedge pclk11);
    p_reset11 = 1'b0;
    check("rstw_writes", age_wr_cnt - wr_base, 0);
    check("rstw_mem", mem[3], e3);

    start_scan(32'd10, 32'd100);
    check("rescan_addr", mem_addr_age11, 0);
    check("rescan_busy", scan_busy11, 1);
    wait_done(lat);
    check("rescan_latency", lat, 515);
    check("rescan_mem", mem[3], mk(1'b0, 32'd5, 2'd1, 48'h0000_0000_0303));
    check("rescan_aged", aged_count11, STATS ? 9'd1 : 9'd0);
    repeat (3) @(negedge pclk11);
    check("rescan_aged_hold", aged_count11, STATS ? 9'd1 : 9'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
